// File: rtl/pcie_trn_tx_framer_pkg.sv
// Shared types and constants for the TRN transmit framer.
package pcie_trn_tx_framer_pkg;

    localparam int unsigned TRN_DW    = 32;
    localparam int unsigned TRN_BEAT  = 64;
    localparam int unsigned HDR_W     = 128;
    localparam int unsigned LEN_W     = 11;
    localparam int unsigned PL_CNT_W  = 10;
    localparam int unsigned H0_LSB    = 96;
    localparam int unsigned H0_FMT_DATA_BIT = 30;
    localparam int unsigned H0_FMT_4DW_BIT  = 29;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR0  = 3'd1,
        ST_HDR1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_FLUSH = 3'd4
    } state_e;

    typedef struct packed {
        logic [TRN_BEAT-1:0] td;
        logic                trem_n;
        logic                sof_n;
        logic                eof_n;
        logic                src_rdy_n;
    } trn_beat_t;

    localparam trn_beat_t BEAT_RESET = '{td: '0, trem_n: 1'b0, sof_n: 1'b1,
                                         eof_n: 1'b1, src_rdy_n: 1'b1};

    // A length field of zero encodes the maximum of 1024 DW.
    function automatic logic [LEN_W-1:0] tlp_len_dw(input logic [9:0] len_field);
        return (len_field == 10'd0) ? 11'd1024 : {1'b0, len_field};
    endfunction

endpackage

// File: rtl/pcie_trn_tx_framer_dw_align.sv
// One-DW holding register that shifts the payload by a DW behind a 3DW header.
module pcie_trn_tx_framer_dw_align
    import pcie_trn_tx_framer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                flush,
    input  logic [TRN_BEAT-1:0] pl_data,
    output logic [TRN_DW-1:0]   held_dw,
    output logic [TRN_BEAT-1:0] aligned
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        held_dw <= '0;
        else if (flush) held_dw <= '0;
        else if (load)  held_dw <= pl_data[TRN_DW-1:0];
    end

    assign aligned = {held_dw, pl_data[TRN_BEAT-1:TRN_DW]};

endmodule

// File: rtl/pcie_trn_tx_framer.sv
// TRN transmit framer: header + payload stream in, 64-bit TRN beats out.
module pcie_trn_tx_framer
    import pcie_trn_tx_framer_pkg::*;
#(
    parameter int unsigned MIN_BUF_AV = 1
) (
    input  logic                trn_clk,
    input  logic                trn_reset,
    input  logic                trn_lnk_up_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [HDR_W-1:0]    req_hdr,
    input  logic [TRN_BEAT-1:0] pl_data,
    input  logic                pl_valid,
    output logic                pl_ready,
    output logic [TRN_BEAT-1:0] trn_td,
    output logic                trn_trem_n,
    output logic                trn_tsof_n,
    output logic                trn_teof_n,
    output logic                trn_tsrc_rdy_n,
    output logic                trn_tsrc_dsc_n,
    output logic                trn_terrfwd_n,
    output logic                trn_tstr_n,
    input  logic                trn_tdst_rdy_n,
    input  logic [5:0]          trn_tbuf_av,
    input  logic                trn_terr_drop_n,
    output logic [15:0]         pkt_count,
    output logic [7:0]          drop_count,
    output logic [7:0]          flush_count
);

    state_e                state, state_nxt;
    trn_beat_t             beat_q, beat_d;
    logic [TRN_DW-1:0]     h2_q, h3_q, held_dw;
    logic [TRN_BEAT-1:0]   aligned;
    logic                  is_data_q, is_4dw_q;
    logic [LEN_W-1:0]      rem_q, rem_d, req_len;
    logic [PL_CNT_W-1:0]   pl_left_q;
    logic out_free, beat_acc, eof_acc, req_acc, link_down, pl_hs;
    logic need_pl, gen, advance, align_load, align_flush, pl_ready_c;

    assign out_free  = beat_q.src_rdy_n | ~trn_tdst_rdy_n;
    assign beat_acc  = ~beat_q.src_rdy_n & ~trn_tdst_rdy_n;
    assign eof_acc   = beat_acc & ~beat_q.eof_n;
    assign req_acc   = req_valid & req_ready;
    assign link_down = trn_lnk_up_n;
    assign pl_hs     = pl_valid & pl_ready_c;
    assign req_len   = tlp_len_dw(req_hdr[H0_LSB+9:H0_LSB]);

    pcie_trn_tx_framer_dw_align u_align (
        .clk     (trn_clk),
        .rst     (trn_reset),
        .load    (align_load),
        .flush   (align_flush),
        .pl_data (pl_data),
        .held_dw (held_dw),
        .aligned (aligned)
    );

    always_ff @(posedge trn_clk or posedge trn_reset) begin
        if (trn_reset) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_acc) state_nxt = ST_HDR0;
            ST_HDR0, ST_HDR1, ST_DATA: begin
                if (eof_acc)        state_nxt = ST_IDLE;
                else if (link_down) state_nxt = ST_FLUSH;
                else if (advance)   state_nxt = (state == ST_HDR0) ? ST_HDR1 : ST_DATA;
            end
            ST_FLUSH: if (pl_left_q == '0 || (pl_valid && pl_left_q == 10'd1))
                          state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next output beat: header beats, realigned or straight payload, bubbles.
    always_comb begin
        beat_d      = beat_q;
        rem_d       = rem_q;
        need_pl     = 1'b0;
        gen         = 1'b0;
        advance     = 1'b0;
        align_load  = 1'b0;
        align_flush = 1'b0;
        pl_ready_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                align_flush = req_acc;
                if (req_acc)
                    beat_d = '{td: req_hdr[HDR_W-1:TRN_BEAT], trem_n: 1'b0, sof_n: 1'b0,
                               eof_n: 1'b1, src_rdy_n: 1'b0};
            end
            ST_HDR0, ST_HDR1, ST_DATA: begin
                gen = ~link_down & out_free & beat_q.eof_n;
                if (state == ST_HDR0) need_pl = is_data_q & ~is_4dw_q;
                else                  need_pl = is_4dw_q | (rem_q >= 11'd2);
                advance     = gen & (~need_pl | pl_valid);
                pl_ready_c  = gen & need_pl;
                align_flush = link_down;
                if (out_free || link_down) begin
                    beat_d.src_rdy_n = 1'b1;
                    beat_d.sof_n     = 1'b1;
                    beat_d.eof_n     = 1'b1;
                end
                if (advance) begin
                    beat_d.src_rdy_n = 1'b0;
                    beat_d.trem_n    = 1'b0;
                    if (state == ST_HDR0) begin
                        if (is_4dw_q) begin
                            beat_d.td    = {h2_q, h3_q};
                            beat_d.eof_n = is_data_q;
                        end else if (!is_data_q) begin
                            beat_d.td     = {h2_q, 32'h0};
                            beat_d.trem_n = 1'b1;
                            beat_d.eof_n  = 1'b0;
                        end else begin
                            beat_d.td    = {h2_q, pl_data[TRN_BEAT-1:TRN_DW]};
                            align_load   = 1'b1;
                            rem_d        = rem_q - 11'd1;
                            beat_d.eof_n = (rem_q != 11'd1);
                        end
                    end else if (is_4dw_q) begin
                        beat_d.td     = pl_data;
                        beat_d.eof_n  = (rem_q > 11'd2);
                        beat_d.trem_n = (rem_q == 11'd1);
                        rem_d         = (rem_q > 11'd2) ? rem_q - 11'd2 : '0;
                    end else if (rem_q == 11'd1) begin
                        beat_d.td     = {held_dw, 32'h0};
                        beat_d.trem_n = 1'b1;
                        beat_d.eof_n  = 1'b0;
                        rem_d         = '0;
                    end else begin
                        beat_d.td    = aligned;
                        align_load   = 1'b1;
                        beat_d.eof_n = (rem_q != 11'd2);
                        rem_d        = rem_q - 11'd2;
                    end
                end
            end
            ST_FLUSH: pl_ready_c = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge trn_clk or posedge trn_reset) begin
        if (trn_reset) begin
            beat_q      <= BEAT_RESET;
            h2_q        <= '0;
            h3_q        <= '0;
            is_data_q   <= 1'b0;
            is_4dw_q    <= 1'b0;
            rem_q       <= '0;
            pl_left_q   <= '0;
            req_ready   <= 1'b0;
            pkt_count   <= '0;
            drop_count  <= '0;
            flush_count <= '0;
        end else begin
            beat_q    <= beat_d;
            req_ready <= (state_nxt == ST_IDLE) & ~link_down &
                         (trn_tbuf_av >= 6'(MIN_BUF_AV));
            if (req_acc) begin
                h2_q      <= req_hdr[63:32];
                h3_q      <= req_hdr[31:0];
                is_data_q <= req_hdr[H0_LSB+H0_FMT_DATA_BIT];
                is_4dw_q  <= req_hdr[H0_LSB+H0_FMT_4DW_BIT];
                rem_q     <= req_hdr[H0_LSB+H0_FMT_DATA_BIT] ? req_len : '0;
                pl_left_q <= req_hdr[H0_LSB+H0_FMT_DATA_BIT] ?
                             PL_CNT_W'((req_len + 11'd1) >> 1) : '0;
            end else begin
                if (advance) rem_q <= rem_d;
                if (pl_hs && pl_left_q != '0) pl_left_q <= pl_left_q - 10'd1;
            end
            if (eof_acc) pkt_count <= pkt_count + 16'd1;
            if (!trn_terr_drop_n && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            if (state == ST_FLUSH && state_nxt == ST_IDLE && flush_count != 8'hFF)
                flush_count <= flush_count + 8'd1;
        end
    end

    assign pl_ready       = pl_ready_c;
    assign trn_td         = beat_q.td;
    assign trn_trem_n     = beat_q.trem_n;
    assign trn_tsof_n     = beat_q.sof_n;
    assign trn_teof_n     = beat_q.eof_n;
    assign trn_tsrc_rdy_n = beat_q.src_rdy_n;
    assign trn_tsrc_dsc_n = 1'b1;
    assign trn_terrfwd_n  = 1'b1;
    assign trn_tstr_n     = 1'b1;

endmodule

// File: tb/tb_pcie_trn_tx_framer.sv
// Scoreboard bench for pcie_trn_tx_framer: TLPs are flattened to DW lists and paired into beats.
module tb_pcie_trn_tx_framer;

    logic         trn_clk, trn_reset, trn_lnk_up_n;
    logic         req_valid, req_ready;
    logic [127:0] req_hdr;
    logic [63:0]  pl_data;
    logic         pl_valid, pl_ready;
    logic [63:0]  trn_td;
    logic         trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n;
    logic         trn_tsrc_dsc_n, trn_terrfwd_n, trn_tstr_n;
    logic         trn_tdst_rdy_n;
    logic [5:0]   trn_tbuf_av;
    logic         trn_terr_drop_n;
    logic [15:0]  pkt_count;
    logic [7:0]   drop_count, flush_count;

    pcie_trn_tx_framer #(.MIN_BUF_AV(1)) dut (
        .trn_clk(trn_clk), .trn_reset(trn_reset), .trn_lnk_up_n(trn_lnk_up_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_hdr(req_hdr),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
        .trn_td(trn_td), .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n),
        .trn_teof_n(trn_teof_n), .trn_tsrc_rdy_n(trn_tsrc_rdy_n),
        .trn_tsrc_dsc_n(trn_tsrc_dsc_n), .trn_terrfwd_n(trn_terrfwd_n),
        .trn_tstr_n(trn_tstr_n), .trn_tdst_rdy_n(trn_tdst_rdy_n),
        .trn_tbuf_av(trn_tbuf_av), .trn_terr_drop_n(trn_terr_drop_n),
        .pkt_count(pkt_count), .drop_count(drop_count), .flush_count(flush_count)
    );

    initial begin
        trn_clk = 1'b0;
        forever #5 trn_clk = ~trn_clk;
    end

    typedef struct {
        logic [63:0] td;
        logic        sof_n;
        logic        eof_n;
        logic        trem_n;
    } exp_beat_t;

    exp_beat_t   exp_q[$];
    logic [63:0] pl_q[$];
    logic [63:0] pl_rest[$];
    int n_checks = 0;
    int n_errors = 0;
    int exp_pkts = 0;
    int tdst_mode = 0;   // 0 ready, 1 toggle, 2 random, 3 stalled
    int pl_prob = 100;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: header DWs then payload DWs, paired two per beat; odd tail has one DW.
    task automatic prep_tlp(input logic [127:0] hdr, input int max_beats, input int max_pl,
                            input bit fixed, input logic [31:0] fill);
        logic [31:0] dw[$];
        logic [31:0] pd[$];
        exp_beat_t   b;
        int          len, n, npl;
        bit          data;
        data = hdr[126];
        len  = (hdr[105:96] == 10'd0) ? 1024 : int'(hdr[105:96]);
        dw.push_back(hdr[127:96]);
        dw.push_back(hdr[95:64]);
        dw.push_back(hdr[63:32]);
        if (hdr[125]) dw.push_back(hdr[31:0]);
        if (data) begin
            for (int i = 0; i < len; i++) pd.push_back(fixed ? fill + 32'(i) : $urandom);
            foreach (pd[i]) dw.push_back(pd[i]);
        end
        n = dw.size();
        for (int i = 0; i < n; i += 2) begin
            if (i / 2 < max_beats) begin
                b.td     = {dw[i], (i + 1 < n) ? dw[i+1] : 32'h0};
                b.sof_n  = (i != 0);
                b.eof_n  = !(i + 2 >= n);
                b.trem_n = (i + 1 >= n);
                exp_q.push_back(b);
            end
        end
        npl = data ? (len + 1) / 2 : 0;
        for (int j = 0; j < npl; j++) begin
            logic [63:0] w;
            w = {pd[2*j], (2*j + 1 < len) ? pd[2*j+1] : 32'($urandom)};
            if (j < max_pl) pl_q.push_back(w);
            else            pl_rest.push_back(w);
        end
    endtask

    task automatic req_handshake(input logic [127:0] hdr);
        int k;
        @(posedge trn_clk); #1;
        req_valid = 1'b1;
        req_hdr   = hdr;
        for (k = 0; k < 3000; k++) begin
            @(negedge trn_clk);
            if (req_ready) break;
        end
        if (k == 3000) chk("req_accept_timeout", 64'(req_ready), 64'd1);
        @(posedge trn_clk); #1;
        req_valid = 1'b0;
        req_hdr   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic send_tlp(input logic [127:0] hdr);
        prep_tlp(hdr, 1 << 20, 1 << 20, 1'b0, 32'h0);
        exp_pkts++;
        req_handshake(hdr);
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 5000; k++) begin
            @(posedge trn_clk);
            if (exp_q.size() == 0 && pl_q.size() == 0) break;
        end
        if (k == 5000) chk(name, 64'(exp_q.size() + pl_q.size()), 64'd0);
        repeat (3) @(posedge trn_clk);
    endtask

    function automatic logic [127:0] make_hdr(input logic [1:0] fmt, input logic [9:0] len);
        return {1'b0, fmt, 5'($urandom), 14'($urandom), len, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        trn_tdst_rdy_n = 1'b0;
        forever begin
            @(posedge trn_clk); #1;
            case (tdst_mode)
                0: trn_tdst_rdy_n = 1'b0;
                1: trn_tdst_rdy_n = ~trn_tdst_rdy_n;
                2: trn_tdst_rdy_n = ($urandom_range(0, 3) == 0);
                default: trn_tdst_rdy_n = 1'b1;
            endcase
        end
    end

    initial begin
        bit hs;
        pl_valid = 1'b0;
        pl_data  = '0;
        forever begin
            @(negedge trn_clk);
            hs = pl_valid && pl_ready;
            @(posedge trn_clk); #1;
            if (hs) void'(pl_q.pop_front());
            if (pl_q.size() > 0 && $urandom_range(0, 99) < pl_prob) begin
                pl_valid = 1'b1;
                pl_data  = pl_q[0];
            end else begin
                pl_valid = 1'b0;
                pl_data  = {$urandom, $urandom};
            end
        end
    end

    // Monitor: every accepted beat is popped and compared; stalled beats must hold.
    bit          pend;
    exp_beat_t   held_b, got_b;
    logic [63:0] mask;
    initial begin
        pend = 1'b0;
        forever begin
            @(negedge trn_clk);
            if (trn_reset) pend = 1'b0;
            else begin
                if (pend && !trn_lnk_up_n) begin
                    chk("hold_td", trn_td, held_b.td);
                    chk("hold_flags", 64'({trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n}),
                        64'({1'b0, held_b.sof_n, held_b.eof_n, held_b.trem_n}));
                end
                pend = 1'b0;
                if (!trn_tsrc_rdy_n) begin
                    if (!trn_tdst_rdy_n) begin
                        if (exp_q.size() == 0) chk("unexpected_beat", 64'(exp_q.size()), 64'd1);
                        else begin
                            got_b = exp_q.pop_front();
                            mask  = got_b.trem_n ? 64'hFFFF_FFFF_0000_0000 : 64'hFFFF_FFFF_FFFF_FFFF;
                            chk("beat_td", trn_td & mask, got_b.td & mask);
                            chk("beat_flags", 64'({trn_tsof_n, trn_teof_n, trn_trem_n}),
                                64'({got_b.sof_n, got_b.eof_n, got_b.trem_n}));
                        end
                    end else begin
                        pend          = 1'b1;
                        held_b.td     = trn_td;
                        held_b.sof_n  = trn_tsof_n;
                        held_b.eof_n  = trn_teof_n;
                        held_b.trem_n = trn_trem_n;
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [127:0] h;
    int k;
    initial begin
        trn_reset = 1'b1; trn_lnk_up_n = 1'b0; req_valid = 1'b0; req_hdr = '0;
        trn_tbuf_av = 6'd8; trn_terr_drop_n = 1'b1;
        repeat (3) @(negedge trn_clk);
        chk("rst_td", trn_td, 64'd0);
        chk("rst_flags", 64'({trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n,
                              trn_tsrc_dsc_n, trn_terrfwd_n, trn_tstr_n}), 64'b1110111);
        chk("rst_ready", 64'({req_ready, pl_ready}), 64'd0);
        chk("rst_counts", 64'({pkt_count, drop_count, flush_count}), 64'd0);
        @(posedge trn_clk); #1;
        trn_reset = 1'b0;

        // 3DW memory read, no payload
        send_tlp({32'h0000_0001, $urandom, $urandom, $urandom});
        wait_idle("mrd_idle");
        @(negedge trn_clk);
        chk("mrd_pkt_count", 64'(pkt_count), 64'(exp_pkts));

        // 3DW write, single DW
        h = {32'h4000_0001, $urandom, $urandom, $urandom};
        prep_tlp(h, 1 << 20, 1 << 20, 1'b1, 32'hA5A5_A5A5);
        exp_pkts++;
        req_handshake(h);
        wait_idle("mwr1_idle");

        // 4DW write len 3 under alternating backpressure
        tdst_mode = 1;
        send_tlp({32'h6000_0003, $urandom, $urandom, $urandom});
        wait_idle("mwr4_idle");
        tdst_mode = 0;
        @(negedge trn_clk);
        chk("mwr4_pkt_count", 64'(pkt_count), 64'(exp_pkts));

        // No buffers: requests must stall until tbuf_av rises
        @(posedge trn_clk); #1;
        trn_tbuf_av = 6'd0;
        repeat (2) @(posedge trn_clk);
        #1;
        h = make_hdr(2'b10, 10'd2);
        prep_tlp(h, 1 << 20, 1 << 20, 1'b0, 32'h0);
        exp_pkts++;
        req_valid = 1'b1;
        req_hdr   = h;
        for (int i = 0; i < 20; i++) begin
            @(negedge trn_clk);
            chk("nobuf_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge trn_clk); #1;
        trn_tbuf_av = 6'd1;
        @(negedge trn_clk);
        chk("buf_ready_delay", 64'(req_ready), 64'd0);
        @(negedge trn_clk);
        chk("buf_ready_up", 64'(req_ready), 64'd1);
        @(posedge trn_clk); #1;
        req_valid = 1'b0;
        @(negedge trn_clk);
        chk("buf_beat0", 64'({trn_tsrc_rdy_n, trn_tsof_n}), 64'd0);
        wait_idle("buf_idle");

        // Randomized traffic mix
        for (int p = 0; p < 16; p++) begin
            tdst_mode = $urandom_range(0, 2);
            pl_prob   = $urandom_range(30, 100);
            send_tlp(make_hdr(2'($urandom_range(0, 3)), 10'($urandom_range(1, 20))));
        end
        wait_idle("rand_idle");
        tdst_mode = 0;
        pl_prob   = 100;
        @(negedge trn_clk);
        chk("rand_pkt_count", 64'(pkt_count), 64'(exp_pkts));

        // Maximum-length 3DW write (len field 0)
        send_tlp(make_hdr(2'b10, 10'd0));
        wait_idle("max_idle");
        @(negedge trn_clk);
        chk("max_pkt_count", 64'(pkt_count), 64'(exp_pkts));

        // Link drop after beat2 of a 4DW len 8 write, with beat3 stalled
        h = make_hdr(2'b11, 10'd8);
        prep_tlp(h, 3, 2, 1'b0, 32'h0);
        req_handshake(h);
        for (k = 0; k < 200; k++) begin
            @(negedge trn_clk); #1;
            if (exp_q.size() == 0) break;
        end
        if (k == 200) chk("abort_wait", 64'(exp_q.size()), 64'd0);
        tdst_mode = 3;
        @(posedge trn_clk); #1;
        trn_lnk_up_n = 1'b1;
        @(negedge trn_clk);
        @(negedge trn_clk);
        chk("abort_src_rdy", 64'(trn_tsrc_rdy_n), 64'd1);
        while (pl_rest.size() > 0) pl_q.push_back(pl_rest.pop_front());
        wait_idle("abort_drain");
        @(negedge trn_clk);
        chk("abort_flush_count", 64'(flush_count), 64'd1);
        chk("abort_pkt_count", 64'(pkt_count), 64'(exp_pkts));
        chk("abort_req_ready", 64'(req_ready), 64'd0);
        @(posedge trn_clk); #1;
        trn_lnk_up_n = 1'b0;
        tdst_mode = 0;
        send_tlp(make_hdr(2'b10, 10'd5));
        wait_idle("post_abort_idle");
        @(negedge trn_clk);
        chk("post_abort_pkt_count", 64'(pkt_count), 64'(exp_pkts));

        // Three drop pulses
        for (int i = 0; i < 3; i++) begin
            @(posedge trn_clk); #1;
            trn_terr_drop_n = 1'b0;
            @(posedge trn_clk); #1;
            trn_terr_drop_n = 1'b1;
        end
        @(negedge trn_clk);
        chk("drop_count", 64'(drop_count), 64'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
